mcu_color_stream: RTL and testbench
===================================

Name: mcu_color_stream

Overview:
- Parametrised successor MCU assembler for the JPEG decoder. Sits between the 2-D IDCT and the pixel writer.
- Accepts whole 8x8 IDCT blocks over a valid/ready handshake and buffers one complete MCU.
- Supports 4:4:4, 4:2:2, 4:2:0 and grayscale sampling, with runtime mode selection.
- Emits raster-ordered RGB pixels over a backpressured valid/ready stream. Each pixel carries in-MCU coordinates and an end-of-MCU flag.

Parameters:
DW, 16, signed IDCT coefficient width
FRAC, 10, fixed-point fraction bits for colour-conversion constants (2..14)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mode  in  2  0=4:4:4, 1=4:2:2, 2=4:2:0, 3=gray; latched when the first block of an MCU is accepted
blk_data  in  64*DW  flattened signed block, element k at bits [k*DW +: DW], raster order
blk_valid  in  1  block present on blk_data
blk_ready  out  1  block accepted on cycle where blk_valid && blk_ready
px_r, px_g, px_b  out  8 each  pixel colour
px_x, px_y  out  4 each  pixel column/row within MCU
px_last  out  1  final pixel of the MCU
px_valid  out  1  pixel output valid
px_ready  in  1  downstream accepts pixel

Behaviour:
- Reset (asynchronous, rst_n low): state=LOAD, blk_idx=0, row=col=0. Output values: px_valid=0, px_last=0, px_r/g/b=0, px_x/px_y=0. Buffer RAM is not reset.
- Per-mode MCU geometry:
  - 4:4:4: blocks Y,Cb,Cr; 8x8 pixels.
  - 4:2:2: blocks Y0,Y1,Cb,Cr; 16 wide x 8 high.
  - 4:2:0: blocks Y0,Y1,Y2,Y3,Cb,Cr; 16x16 pixels.
  - gray: block Y only; 8x8 pixels; Cb=Cr=0.
- State LOAD:
  - blk_ready=1.
  - On each accepted block: store it to the slot given by blk_idx, then blk_idx++.
  - On blk_idx==0 acceptance, latch mode into mode_q. Mode changes mid-MCU are ignored.
  - When the final block for mode_q is accepted: blk_idx←0, row=col=0, go to EMIT.
- State EMIT:
  - blk_ready=0.
  - Output register loads the next pixel when !px_valid || px_ready.
  - Loaded values: px_x=col, px_y=row, px_last = (last row && last col), and the converted colour.
  - col/row then advance in raster order.
  - After the last pixel is loaded into the output register, go to LOAD the same cycle. The output register no longer needs the buffers, so a new MCU may start loading while the last pixel waits on px_ready.
- px_valid lifecycle:
  - px_valid clears when the register fires and no new pixel is loaded.
  - While px_valid && !px_ready, all px_* outputs are held stable.
- Latency: the first pixel is presented on the cycle after the final block is accepted. Sustained throughput is 1 pixel/clk with px_ready high.
- Sample addressing:
  - Y block select is (row>>3)*2 + (col>>3) for 4:2:0, and (col>>3) for 4:2:2. The in-block index is (row&7)*8 + (col&7).
  - Chroma index:
    - 4:4:4: row*8+col.
    - 4:2:2: row*8+(col>>1).
    - 4:2:0: (row>>1)*8+(col>>1).
- Conversion:
  - Y'=Y+128.
  - Constants are round(c*2^FRAC) for c=1.402, 0.344136, 0.714136, 1.772 (FRAC=10 gives 1436, 352, 731, 1815).
  - R=Y'·2^F+Kr·Cr; G=Y'·2^F−Kg1·Cb−Kg2·Cr; B=Y'·2^F+Kb·Cb.
  - Arithmetic is signed at DW+FRAC+4 bits. Add 2^(FRAC−1), arithmetic shift right by FRAC, then clamp to 0..255.
- Reset mid-operation: abandons the current MCU. The next accepted block is treated as blk_idx 0.
- blk_valid in EMIT is ignored; no block is lost because blk_ready=0.

Decomposition:
- Package jpeg_color_pkg holds:
  - mode encodings;
  - a function giving blocks-per-MCU and MCU width/height per mode;
  - a function computing the four conversion constants from FRAC.
- One sub-module, ycc2rgb_px: combinational Y/Cb/Cr (DW) → clamped 8-bit R/G/B, parametrised by DW and FRAC.

Test Plan:
- 4:4:4, all blocks zero, px_ready=1 → 64 pixels, each (128,128,128); px_last only on (x=7,y=7); first px_valid 1 cycle after the Cr block is accepted.
- 4:4:4, Y=127 and Cr=127 everywhere, Cb=0 → every pixel (255,164,255): R clamped, G=255−90.66 rounded.
- 4:2:0, six blocks, Y=0, Cb[0]=64 and all else 0 → pixels (0,0),(1,0),(0,1),(1,1) are (128,106,241); all others (128,128,128); 256 pixels total; blk_ready=0 throughout EMIT.
- 4:2:2, Y1 block=10, all else 0 → columns 8..15 are (138,138,138), columns 0..7 are (128,128,128); 128 pixels; px_last at (15,7).
- Backpressure: 4:2:0, px_ready low for 5 cycles when pixel 10 is presented → px_* stable for those cycles; the full 256-pixel sequence is intact; next-MCU blocks are accepted while the last pixel is stalled.
- Gray: one block, then mode switched to 4:2:0 mid-EMIT → 64 gray pixels; the next MCU is latched as 4:2:0. Reset asserted at pixel 20 → px_valid=0 immediately; the next block is loaded as blk_idx 0.

Source files
------------

// File: rtl/jpeg_color_pkg.sv
// jpeg_color_pkg: sampling modes, MCU geometry and colour-conversion constants for the MCU assembler
package jpeg_color_pkg;
  typedef enum logic [1:0] {M444 = 2'd0, M422 = 2'd1, M420 = 2'd2, MGRAY = 2'd3} mode_e;
  typedef enum logic {LOAD = 1'b0, EMIT = 1'b1} state_e;
  typedef struct packed {
    logic [2:0] nblk;
    logic [4:0] w;
    logic [4:0] h;
  } geom_t;
  typedef struct packed {
    int kr;
    int kg1;
    int kg2;
    int kb;
  } ck_t;
  localparam int NSLOT = 6;
  function automatic geom_t mcu_geom(input mode_e m);
    case (m)
      M444:    return '{3'd3, 5'd8, 5'd8};
      M422:    return '{3'd4, 5'd16, 5'd8};
      M420:    return '{3'd6, 5'd16, 5'd16};
      default: return '{3'd1, 5'd8, 5'd8};
    endcase
  endfunction
  // c_micro is the constant scaled by 1e6, so rounding stays in integer arithmetic
  function automatic int kround(input longint c_micro, input int frac);
    return int'((c_micro * (longint'(1) << frac) + 64'sd500000) / 64'sd1000000);
  endfunction
  function automatic ck_t color_k(input int frac);
    return '{kround(64'sd1402000, frac), kround(64'sd344136, frac),
             kround(64'sd714136, frac), kround(64'sd1772000, frac)};
  endfunction
endpackage

// File: rtl/mcu_color_stream_ycc2rgb_px.sv
// ycc2rgb_px: combinational level-shifted YCbCr to clamped 8-bit RGB
module ycc2rgb_px import jpeg_color_pkg::*; #(
  parameter int DW   = 16,
  parameter int FRAC = 10
) (
  input  logic signed [DW-1:0] y,
  input  logic signed [DW-1:0] cb,
  input  logic signed [DW-1:0] cr,
  output logic [7:0]           r,
  output logic [7:0]           g,
  output logic [7:0]           b
);
  localparam int W = DW + FRAC + 4;
  localparam ck_t K = color_k(FRAC);
  localparam logic signed [W-1:0] KR   = W'(K.kr);
  localparam logic signed [W-1:0] KG1  = W'(K.kg1);
  localparam logic signed [W-1:0] KG2  = W'(K.kg2);
  localparam logic signed [W-1:0] KB   = W'(K.kb);
  localparam logic signed [W-1:0] RND  = W'(2 ** (FRAC - 1));
  localparam logic signed [W-1:0] MAXV = W'(255);
  logic signed [W-1:0] yb, cbw, crw, rs, gs, bs;
  function automatic logic [7:0] clamp8(input logic signed [W-1:0] v);
    return v[W-1] ? 8'd0 : (v > MAXV) ? 8'd255 : v[7:0];
  endfunction
  always_comb begin
    yb  = (W'(y) + W'(128)) <<< FRAC;
    cbw = W'(cb);
    crw = W'(cr);
    rs  = (yb + KR * crw + RND) >>> FRAC;
    gs  = (yb - KG1 * cbw - KG2 * crw + RND) >>> FRAC;
    bs  = (yb + KB * cbw + RND) >>> FRAC;
  end
  assign r = clamp8(rs);
  assign g = clamp8(gs);
  assign b = clamp8(bs);
endmodule

// File: rtl/mcu_color_stream.sv
// mcu_color_stream: buffers one MCU of IDCT blocks and streams raster-ordered RGB pixels
module mcu_color_stream import jpeg_color_pkg::*; #(
  parameter int DW   = 16,
  parameter int FRAC = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [64*DW-1:0] blk_data,
  input  logic             blk_valid,
  output logic             blk_ready,
  output logic [7:0]       px_r,
  output logic [7:0]       px_g,
  output logic [7:0]       px_b,
  output logic [3:0]       px_x,
  output logic [3:0]       px_y,
  output logic             px_last,
  output logic             px_valid,
  input  logic             px_ready
);
  state_e state, state_n;
  mode_e mode_q, m_eff;
  geom_t geo;
  logic [2:0] blk_idx, blk_idx_n, ys_slot, cb_slot, cr_slot;
  logic [3:0] row, col, row_n, col_n;
  logic [5:0] y_idx, c_idx;
  logic acc, fin, ld, last_col, last_row;
  logic signed [DW-1:0] mem [NSLOT][64];
  logic signed [DW-1:0] y_s, cb_s, cr_s;
  logic [7:0] r_c, g_c, b_c;
  assign blk_ready = state == LOAD;
  assign acc       = blk_valid && blk_ready;
  assign m_eff     = (state == LOAD && blk_idx == 3'd0) ? mode_e'(mode) : mode_q;
  assign geo       = mcu_geom(m_eff);
  assign fin       = acc && blk_idx == geo.nblk - 3'd1;
  assign ld        = (state == EMIT || fin) && (!px_valid || px_ready);
  assign last_col  = col == 4'(geo.w - 5'd1);
  assign last_row  = row == 4'(geo.h - 5'd1);
  // the final block is bypassed from blk_data so pixel 0 can load on its acceptance edge
  always_comb begin
    ys_slot = m_eff == M420 ? {1'b0, row[3], col[3]} : m_eff == M422 ? {2'b00, col[3]} : 3'd0;
    cb_slot = m_eff == M420 ? 3'd4 : m_eff == M422 ? 3'd2 : 3'd1;
    cr_slot = cb_slot + 3'd1;
    y_idx   = {row[2:0], col[2:0]};
    c_idx   = m_eff == M420 ? {row[3:1], col[3:1]} :
              m_eff == M422 ? {row[2:0], col[3:1]} : {row[2:0], col[2:0]};
    y_s     = (fin && blk_idx == ys_slot) ? $signed(blk_data[y_idx*DW +: DW]) : mem[ys_slot][y_idx];
    cb_s    = m_eff == MGRAY ? '0 :
              (fin && blk_idx == cb_slot) ? $signed(blk_data[c_idx*DW +: DW]) : mem[cb_slot][c_idx];
    cr_s    = m_eff == MGRAY ? '0 :
              (fin && blk_idx == cr_slot) ? $signed(blk_data[c_idx*DW +: DW]) : mem[cr_slot][c_idx];
  end
  ycc2rgb_px #(.DW(DW), .FRAC(FRAC)) u_cvt (
    .y (y_s),
    .cb(cb_s),
    .cr(cr_s),
    .r (r_c),
    .g (g_c),
    .b (b_c)
  );
  always_comb begin
    state_n   = state;
    blk_idx_n = blk_idx;
    row_n     = row;
    col_n     = col;
    if (acc) begin
      blk_idx_n = fin ? 3'd0 : blk_idx + 3'd1;
      state_n   = fin ? EMIT : LOAD;
    end
    if (ld) begin
      col_n   = last_col ? 4'd0 : col + 4'd1;
      row_n   = last_col ? (last_row ? 4'd0 : row + 4'd1) : row;
      state_n = (last_col && last_row) ? LOAD : EMIT;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOAD;
      blk_idx <= '0;
      row     <= '0;
      col     <= '0;
      mode_q  <= M444;
    end else begin
      state   <= state_n;
      blk_idx <= blk_idx_n;
      row     <= row_n;
      col     <= col_n;
      if (acc && blk_idx == 3'd0) mode_q <= mode_e'(mode);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_valid <= 1'b0;
      px_last  <= 1'b0;
      px_r     <= '0;
      px_g     <= '0;
      px_b     <= '0;
      px_x     <= '0;
      px_y     <= '0;
    end else if (ld) begin
      px_valid <= 1'b1;
      px_last  <= last_col && last_row;
      px_r     <= r_c;
      px_g     <= g_c;
      px_b     <= b_c;
      px_x     <= col;
      px_y     <= row;
    end else if (px_ready) begin
      px_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (acc) for (int k = 0; k < 64; k++) mem[blk_idx][k] <= $signed(blk_data[k*DW +: DW]);
  end
endmodule

// File: tb/tb_mcu_color_stream.sv
// tb_mcu_color_stream: directed scoreboard bench for the MCU colour stream
module tb_mcu_color_stream;
  localparam int DW = 16;
  localparam int BOUND = 3000;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [3:0] x;
    logic [3:0] y;
    logic       last;
  } px_t;
  logic clk = 1'b0;
  logic rst_n, blk_valid, blk_ready, px_last, px_valid, px_ready;
  logic [1:0] mode;
  logic [64*DW-1:0] blk_data, d;
  logic [7:0] px_r, px_g, px_b;
  logic [3:0] px_x, px_y;
  logic [63:0] snap;
  px_t sb[$];
  px_t got, want;
  int checks = 0, failures = 0, npx = 0, ready_viol = 0, npx0, t;

  mcu_color_stream #(.DW(DW), .FRAC(10)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .blk_data(blk_data), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .px_r(px_r), .px_g(px_g), .px_b(px_b), .px_x(px_x), .px_y(px_y),
    .px_last(px_last), .px_valid(px_valid), .px_ready(px_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] w);
    checks++;
    if (g !== w) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", nm, g, w);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && px_valid && blk_ready && !px_last) ready_viol++;
    if (rst_n && px_valid && px_ready) begin
      got = '{px_r, px_g, px_b, px_x, px_y, px_last};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL px_unexpected got x=%0d y=%0d rgb=%0d,%0d,%0d required=none", px_x, px_y, px_r, px_g, px_b);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL px got x=%0d y=%0d rgb=%0d,%0d,%0d last=%0d required x=%0d y=%0d rgb=%0d,%0d,%0d last=%0d",
                   got.x, got.y, got.r, got.g, got.b, got.last, want.x, want.y, want.r, want.g, want.b, want.last);
        end
      end
      npx++;
    end
  end

  function automatic logic [64*DW-1:0] fill(input int v);
    logic [64*DW-1:0] f;
    for (int k = 0; k < 64; k++) f[k*DW +: DW] = DW'(v);
    return f;
  endfunction

  task automatic push_px(input int x, input int y, input int w, input int h, input int r, input int g, input int b);
    sb.push_back('{8'(r), 8'(g), 8'(b), 4'(x), 4'(y), (x == w - 1 && y == h - 1)});
  endtask

  task automatic push_flat(input int w, input int h, input int n, input int v);
    for (int i = 0; i < n; i++) push_px(i % w, i / w, w, h, v, v, v);
  endtask

  task automatic push_cb64();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        if (x < 2 && y < 2) push_px(x, y, 16, 16, 128, 106, 241);
        else push_px(x, y, 16, 16, 128, 128, 128);
  endtask

  task automatic send_block(input logic [1:0] m, input logic [64*DW-1:0] dat);
    int n = 0;
    mode = m;
    blk_data = dat;
    blk_valid = 1'b1;
    while (!blk_ready && n < BOUND) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    blk_valid = 1'b0;
    chk("blk_accept_in_time", 64'(n < BOUND), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < BOUND) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_remaining", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; blk_valid = 1'b0; px_ready = 1'b1; mode = 2'd0; blk_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_px_valid", 64'(px_valid), 64'd0);
    chk("rst_px_last", 64'(px_last), 64'd0);
    chk("rst_rgb", 64'({px_r, px_g, px_b}), 64'd0);
    chk("rst_xy", 64'({px_x, px_y}), 64'd0);
    chk("rst_blk_ready", 64'(blk_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // 4:4:4 all zero, with first-pixel latency
    push_flat(8, 8, 64, 128);
    send_block(2'd0, fill(0));
    send_block(2'd0, fill(0));
    chk("lat_before_cr", 64'(px_valid), 64'd0);
    send_block(2'd0, fill(0));
    chk("lat_valid_after_cr", 64'(px_valid), 64'd1);
    chk("lat_first_xy", 64'({px_x, px_y}), 64'd0);
    drain();
    // 4:4:4 saturating red/blue
    push_flat(8, 8, 0, 0);
    for (int i = 0; i < 64; i++) push_px(i % 8, i / 8, 8, 8, 255, 164, 255);
    send_block(2'd0, fill(127));
    send_block(2'd0, fill(0));
    send_block(2'd0, fill(127));
    drain();
    // 4:2:0 with Cb[0]=64; later blocks carry a different mode that must be ignored
    push_cb64();
    d = fill(0);
    d[DW-1:0] = DW'(64);
    send_block(2'd2, fill(0));
    send_block(2'd0, fill(0));
    send_block(2'd1, fill(0));
    send_block(2'd3, fill(0));
    send_block(2'd0, d);
    send_block(2'd0, fill(0));
    drain();
    chk("blk_ready_low_in_emit", 64'(ready_viol), 64'd0);
    // 4:2:2 with Y1=10
    for (int i = 0; i < 128; i++) push_px(i % 16, i / 16, 16, 8, (i % 16) >= 8 ? 138 : 128,
                                          (i % 16) >= 8 ? 138 : 128, (i % 16) >= 8 ? 138 : 128);
    send_block(2'd1, fill(0));
    send_block(2'd1, fill(10));
    send_block(2'd1, fill(0));
    send_block(2'd1, fill(0));
    drain();
    // backpressure on pixel 10 and on the last pixel
    push_cb64();
    for (int i = 0; i < 6; i++) send_block(2'd2, i == 4 ? d : fill(0));
    t = 0;
    while (!(px_valid && px_x == 4'd10 && px_y == 4'd0) && t < BOUND) begin
      @(posedge clk); #1;
      t++;
    end
    chk("stall_reach_px10", 64'(t < BOUND), 64'd1);
    px_ready = 1'b0;
    snap = 64'({px_valid, px_last, px_r, px_g, px_b, px_x, px_y});
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_hold", 64'({px_valid, px_last, px_r, px_g, px_b, px_x, px_y}), snap);
    end
    px_ready = 1'b1;
    t = 0;
    while (!(px_valid && px_last) && t < BOUND) begin
      @(posedge clk); #1;
      t++;
    end
    chk("stall_reach_last", 64'(t < BOUND), 64'd1);
    px_ready = 1'b0;
    // gray MCU loaded while the last 4:2:0 pixel waits; Cb/Cr content must not matter
    push_flat(8, 8, 64, 100);
    send_block(2'd3, fill(-28));
    chk("last_held_during_load", 64'({px_valid, px_last, px_x, px_y}), 64'({1'b1, 1'b1, 4'd15, 4'd15}));
    mode = 2'd2;
    px_ready = 1'b1;
    drain();
    // next MCU latched as 4:2:0, reset asserted while pixel 20 is presented
    push_flat(16, 16, 20, 128);
    npx0 = npx;
    send_block(2'd2, fill(0));
    for (int i = 0; i < 5; i++) send_block(2'd3, fill(0));
    t = 0;
    while (!(npx == npx0 + 20 && px_valid) && t < BOUND) begin
      @(posedge clk); #1;
      t++;
    end
    chk("reach_px20", 64'(t < BOUND), 64'd1);
    chk("px20_xy", 64'({px_x, px_y}), 64'({4'd4, 4'd1}));
    rst_n = 1'b0;
    #1;
    chk("midrst_px_valid", 64'(px_valid), 64'd0);
    chk("midrst_px_last", 64'(px_last), 64'd0);
    chk("midrst_sb_consumed", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_flat(8, 8, 64, 155);
    send_block(2'd3, fill(27));
    drain();
    chk("blk_ready_low_in_emit_all", 64'(ready_viol), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
